// File: rtl/apb_completer_regfile_if.sv
`default_nettype none
// ============================================================================
//  Module   : apb_completer_regfile_if
//  Brief    : APB bus bundle between a requester and the register-file completer.
//  Revision : 1.0  initial release
// ============================================================================
interface apb_completer_regfile_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface
`default_nettype wire

// File: rtl/apb_completer_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : apb_completer_regfile
//  Brief    : APB completer over a DEPTH-entry register file with fixed wait
//             states, PSLVERR on out-of-range addresses and violation flag.
//  Revision : 1.0  initial release
// ============================================================================
module apb_completer_regfile #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic                    pclk,
  input  logic                    presetn,
  apb_completer_regfile_if.slave  apb,
  output logic                    proto_err
);

  localparam int          c_idx_w     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] c_depth     = 32'(DEPTH);
  localparam logic [3:0]  c_wait      = 4'(WAIT_STATES);
  localparam logic [0:0]  c_st_idle   = 1'b0;
  localparam logic [0:0]  c_st_access = 1'b1;

  logic [0:0]            r_state;
  logic [0:0]            w_next_state;
  logic [3:0]            r_cnt;
  logic [c_idx_w-1:0]    r_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_write;
  logic                  r_err;
  logic                  r_pready;
  logic                  r_pslverr;
  logic                  r_proto;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_setup;
  logic                  w_access;
  logic                  w_in_err;
  logic [c_idx_w-1:0]    w_in_idx;
  logic                  w_capture;
  logic                  w_count;
  logic                  w_set_ready;
  logic                  w_commit;
  logic                  w_proto;
  logic                  w_sel_err;
  logic                  w_sel_write;
  logic [c_idx_w-1:0]    w_sel_idx;

  assign w_setup  = apb.psel & ~apb.penable;
  assign w_access = apb.psel &  apb.penable;
  // Range check on the full address; only the low bits index the array.
  assign w_in_err = (32'(apb.paddr) >= c_depth);
  assign w_in_idx = apb.paddr[c_idx_w-1:0];

  // State register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_setup) begin
          w_next_state = c_st_access;
        end
      end
      c_st_access: begin
        if (r_pready || !w_access) begin
          w_next_state = c_st_idle;
        end
      end
      default: w_next_state = c_st_idle;
    endcase
  end

  // Control decode
  always_comb begin
    w_capture   = 1'b0;
    w_count     = 1'b0;
    w_set_ready = 1'b0;
    w_commit    = 1'b0;
    w_proto     = 1'b0;
    case (r_state)
      c_st_idle: begin
        w_capture   = w_setup;
        w_set_ready = w_setup && (c_wait == 4'd0);
        w_proto     = w_access;
      end
      c_st_access: begin
        if (r_pready) begin
          w_commit = r_write & ~r_err;
        end else if (w_access) begin
          w_count     = (r_cnt != 4'd0);
          w_set_ready = (r_cnt == 4'd1);
        end else begin
          w_proto = 1'b1;
        end
      end
      default: begin
        w_proto = 1'b0;
      end
    endcase
  end

  // Zero-wait completion must use the live setup values, not the captured ones.
  assign w_sel_err   = w_capture ? w_in_err   : r_err;
  assign w_sel_write = w_capture ? apb.pwrite : r_write;
  assign w_sel_idx   = w_capture ? w_in_idx   : r_idx;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_wdata   <= '0;
      r_write   <= 1'b0;
      r_err     <= 1'b0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_proto   <= 1'b0;
      r_prdata  <= '0;
    end else begin
      r_proto   <= w_proto;
      r_pready  <= w_set_ready;
      r_pslverr <= w_set_ready & w_sel_err;
      r_prdata  <= (w_set_ready && !w_sel_write && !w_sel_err) ? r_mem[w_sel_idx] : '0;
      if (w_capture) begin
        r_idx   <= w_in_idx;
        r_wdata <= apb.pwdata;
        r_write <= apb.pwrite;
        r_err   <= w_in_err;
        r_cnt   <= c_wait;
      end else if (w_count) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // Writes land at the end of the pready cycle, so a reset there drops them.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_commit) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign apb.pready  = r_pready;
  assign apb.pslverr = r_pslverr;
  assign apb.prdata  = r_prdata;
  assign proto_err   = r_proto;

endmodule
`default_nettype wire
